sv32_ptw: RTL and testbench

Hardware page-table walker for Sv32 that services TLB misses. On a miss it reads level-1 and, if needed, level-0 PTEs over a single-outstanding memory read port. It checks each PTE for structural validity and drives the TLB fill interface with the resolved VPN/PPN/permissions/superpage flag. It sits between the MMU miss logic (upstream) and the fully-associative TLB fill port and data-side memory arbiter (downstream).

---
 rtl/sv32_ptw.sv | 185 ++++++++++++++++++
 tb/tb_sv32_ptw.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv32_ptw.sv
// sv32_ptw: Sv32 hardware page-table walker.
// Walks the two-level table over a single-outstanding read port and
// either fills the TLB or reports a page or access fault.
//
// state | meaning
// IDLE  | ready for a new walk
// L1    | reading the level-1 PTE
// L0    | reading the level-0 PTE
// DONE  | one-cycle fill + completion pulse
// FAULT | one-cycle completion pulse with a fault flag
// DRAIN | walk aborted by flush; waiting out the pending read
module sv32_ptw #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] satp_i,
    input  logic        walk_req_i,
    input  logic [31:0] walk_vaddr_i,
    output logic        walk_ready_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        fill_req_o,
    output logic [19:0] fill_vpn_o,
    output logic [21:0] fill_ppn_o,
    output logic [6:0]  fill_perm_o,
    output logic        fill_superpage_o,
    output logic        done_o,
    output logic        page_fault_o,
    output logic        access_fault_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1,
        S_L0,
        S_DONE,
        S_FAULT,
        S_DRAIN
    } state_t;

    // Last wait-count value before the read is declared lost.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [19:0] vpn_q, vpn_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pf_q, pf_d;
    logic [19:0] fvpn_q, fvpn_d;
    logic [21:0] fppn_q, fppn_d;
    logic [6:0]  fperm_q, fperm_d;
    logic        fsp_q, fsp_d;

    logic        pte_v, pte_r, pte_w, pte_x, pte_a;
    logic        pte_leaf, pte_bad;
    logic [21:0] pte_ppn;
    logic        unused_ok;

    assign pte_v    = mem_rdata_i[0];
    assign pte_r    = mem_rdata_i[1];
    assign pte_w    = mem_rdata_i[2];
    assign pte_x    = mem_rdata_i[3];
    assign pte_a    = mem_rdata_i[6];
    assign pte_ppn  = mem_rdata_i[31:10];
    assign pte_leaf = pte_r | pte_x;
    // A/D bits are never written back, so a leaf with A=0 must fault.
    assign pte_bad  = !pte_v || (!pte_r && pte_w) || (pte_leaf && !pte_a);

    assign unused_ok = ^{satp_i[31:20], walk_vaddr_i[11:0], mem_rdata_i[9:8]};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vpn_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            pf_q    <= 1'b0;
            fvpn_q  <= '0;
            fppn_q  <= '0;
            fperm_q <= '0;
            fsp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vpn_q   <= vpn_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            pf_q    <= pf_d;
            fvpn_q  <= fvpn_d;
            fppn_q  <= fppn_d;
            fperm_q <= fperm_d;
            fsp_q   <= fsp_d;
        end
    end

    // Next-state logic: PTE checks, level stepping, timeout and flush handling.
    always_comb begin
        state_d = state_q;
        vpn_d   = vpn_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        pf_d    = pf_q;
        fvpn_d  = fvpn_q;
        fppn_d  = fppn_q;
        fperm_d = fperm_q;
        fsp_d   = fsp_q;
        case (state_q)
            S_IDLE: begin
                if (!flush_i && walk_req_i) begin
                    vpn_d   = walk_vaddr_i[31:12];
                    addr_d  = {satp_i[19:0], walk_vaddr_i[31:22], 2'b00};
                    cnt_d   = '0;
                    state_d = S_L1;
                end
            end
            S_L1, S_L0: begin
                if (flush_i) begin
                    // Ack in the flush cycle retires the read; otherwise wait it out.
                    state_d = mem_ack_i ? S_IDLE : S_DRAIN;
                end else if (mem_ack_i) begin
                    if (mem_err_i) begin
                        pf_d    = 1'b0;
                        state_d = S_FAULT;
                    end else if (pte_bad) begin
                        pf_d    = 1'b1;
                        state_d = S_FAULT;
                    end else if (pte_leaf) begin
                        if (state_q == S_L1 && pte_ppn[9:0] != 10'd0) begin
                            pf_d    = 1'b1;
                            state_d = S_FAULT;
                        end else begin
                            fvpn_d  = vpn_q;
                            fppn_d  = pte_ppn;
                            fperm_d = mem_rdata_i[7:1];
                            fsp_d   = (state_q == S_L1);
                            state_d = S_DONE;
                        end
                    end else if (state_q == S_L1) begin
                        addr_d  = {pte_ppn[19:0], vpn_q[9:0], 2'b00};
                        cnt_d   = '0;
                        state_d = S_L0;
                    end else begin
                        pf_d    = 1'b1;
                        state_d = S_FAULT;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    pf_d    = 1'b0;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DRAIN: begin
                if (mem_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE, S_FAULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign walk_ready_o     = (state_q == S_IDLE);
    assign mem_req_o        = (state_q == S_L1) || (state_q == S_L0) || (state_q == S_DRAIN);
    assign mem_addr_o       = addr_q;
    assign fill_vpn_o       = fvpn_q;
    assign fill_ppn_o       = fppn_q;
    assign fill_perm_o      = fperm_q;
    assign fill_superpage_o = fsp_q;
    // A flush in the completion cycle suppresses the pulse entirely.
    assign fill_req_o       = (state_q == S_DONE) && !flush_i;
    assign done_o           = ((state_q == S_DONE) || (state_q == S_FAULT)) && !flush_i;
    assign page_fault_o     = (state_q == S_FAULT) && pf_q && !flush_i;
    assign access_fault_o   = (state_q == S_FAULT) && !pf_q && !flush_i;

endmodule

// File: tb/tb_sv32_ptw.sv
// tb_sv32_ptw: randomized and directed walks checked against a
// rule-level reference model of the Sv32 walk.
module tb_sv32_ptw;

    localparam int TO = 255;
    localparam int NO_ACK = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] satp_i;
    logic        walk_req_i;
    logic [31:0] walk_vaddr_i;
    logic        walk_ready_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic        fill_req_o;
    logic [19:0] fill_vpn_o;
    logic [21:0] fill_ppn_o;
    logic [6:0]  fill_perm_o;
    logic        fill_superpage_o;
    logic        done_o;
    logic        page_fault_o;
    logic        access_fault_o;

    int checks = 0;
    int errors = 0;

    sv32_ptw #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .satp_i           (satp_i),
        .walk_req_i       (walk_req_i),
        .walk_vaddr_i     (walk_vaddr_i),
        .walk_ready_o     (walk_ready_o),
        .flush_i          (flush_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ack_i        (mem_ack_i),
        .mem_rdata_i      (mem_rdata_i),
        .mem_err_i        (mem_err_i),
        .fill_req_o       (fill_req_o),
        .fill_vpn_o       (fill_vpn_o),
        .fill_ppn_o       (fill_ppn_o),
        .fill_perm_o      (fill_perm_o),
        .fill_superpage_o (fill_superpage_o),
        .done_o           (done_o),
        .page_fault_o     (page_fault_o),
        .access_fault_o   (access_fault_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] satp;
        logic [31:0] vaddr;
        logic [31:0] pte1;
        logic [31:0] pte0;
        bit          err1;
        bit          err0;
        int          lat1;
        int          lat0;
    } vec_t;

    // outcome: 0 fill, 1 page fault, 2 access fault, 3 malformed completion
    typedef struct {
        int          outcome;
        int          nreq;
        logic [31:0] addr1;
        logic [31:0] addr0;
        int          done_cyc;
        logic [19:0] vpn;
        logic [21:0] ppn;
        logic [6:0]  perm;
        bit          sp;
        bit          stable;
        bit          hung;
        bit          rdy;
        bit          req_at_done;
    } res_t;

    function automatic vec_t mkvec(logic [31:0] satp, logic [31:0] vaddr, logic [31:0] p1,
                                   logic [31:0] p0, bit e1, bit e0, int l1, int l0);
        vec_t v;
        v.satp = satp; v.vaddr = vaddr; v.pte1 = p1; v.pte0 = p0;
        v.err1 = e1; v.err0 = e0; v.lat1 = l1; v.lat0 = l0;
        return v;
    endfunction

    // Reference: physical address = ppn * 4096 + vpn_i * 4, low 32 bits;
    // each read costs (latency + 1) cycles, a lost read costs TO cycles.
    function automatic res_t model(vec_t v);
        res_t        e;
        bit          fin;
        int          lat;
        bit          err;
        logic [31:0] pte, base, idx;
        bit          pv, pr, pw, px, pa;
        e = '{default: 0};
        e.stable = 1; e.rdy = 1; e.done_cyc = 1; e.vpn = v.vaddr[31:12];
        base = {10'd0, v.satp[21:0]};
        idx  = v.vaddr >> 22;
        e.addr1 = base * 32'd4096 + idx * 32'd4;
        e.nreq = 1;
        fin = 0;
        for (int lvl = 1; lvl >= 0; lvl--) begin
            if (!fin) begin
                lat = (lvl == 1) ? v.lat1 : v.lat0;
                err = (lvl == 1) ? v.err1 : v.err0;
                pte = (lvl == 1) ? v.pte1 : v.pte0;
                pv = pte[0]; pr = pte[1]; pw = pte[2]; px = pte[3]; pa = pte[6];
                fin = 1;
                if (lat >= NO_ACK) begin
                    e.outcome = 2; e.done_cyc += TO;
                end else begin
                    e.done_cyc += lat + 1;
                    if (err) e.outcome = 2;
                    else if (!pv || (pw && !pr) || ((pr || px) && !pa)) e.outcome = 1;
                    else if (pr || px) begin
                        if (lvl == 1 && ((pte >> 10) % 1024) != 0) e.outcome = 1;
                        else begin
                            e.outcome = 0;
                            e.ppn  = 22'(pte >> 10);
                            e.perm = 7'((pte >> 1) & 32'h7f);
                            e.sp   = (lvl == 1);
                        end
                    end else if (lvl == 0) e.outcome = 1;
                    else begin
                        idx = (v.vaddr >> 12) % 1024;
                        e.addr0 = (pte >> 10) * 32'd4096 + idx * 32'd4;
                        e.nreq = 2;
                        fin = 0;
                    end
                end
            end
        end
        return e;
    endfunction

    // Issues one walk and acts as the memory; observes but does not judge.
    task automatic do_walk(input vec_t v, output res_t o);
        int          c, wc;
        bit          prev_ack;
        logic [31:0] cur;
        o = '{default: 0};
        @(negedge clk);
        o.rdy = walk_ready_o;
        walk_req_i = 1; walk_vaddr_i = v.vaddr; satp_i = v.satp;
        @(negedge clk);
        walk_req_i = 0;
        c = 1; wc = 0; prev_ack = 1; o.stable = 1; o.hung = 1; cur = '0;
        while (c < 600) begin
            mem_ack_i = 0; mem_err_i = 0; mem_rdata_i = $urandom;
            if (done_o) begin
                o.hung = 0; o.done_cyc = c; o.req_at_done = mem_req_o;
                o.vpn = fill_vpn_o; o.ppn = fill_ppn_o; o.perm = fill_perm_o; o.sp = fill_superpage_o;
                if (fill_req_o && !page_fault_o && !access_fault_o) o.outcome = 0;
                else if (!fill_req_o && page_fault_o && !access_fault_o) o.outcome = 1;
                else if (!fill_req_o && !page_fault_o && access_fault_o) o.outcome = 2;
                else o.outcome = 3;
                break;
            end
            if (mem_req_o) begin
                if (prev_ack) begin
                    o.nreq++; cur = mem_addr_o; wc = 0;
                    if (o.nreq == 1) o.addr1 = mem_addr_o;
                    else o.addr0 = mem_addr_o;
                end else if (mem_addr_o !== cur) o.stable = 0;
                if (wc == ((o.nreq == 1) ? v.lat1 : v.lat0)) begin
                    mem_ack_i = 1;
                    mem_err_i = (o.nreq == 1) ? v.err1 : v.err0;
                    mem_rdata_i = (o.nreq == 1) ? v.pte1 : v.pte0;
                    prev_ack = 1;
                end else begin
                    prev_ack = 0; wc++;
                end
            end else prev_ack = 1;
            @(negedge clk);
            c++;
        end
        mem_ack_i = 0; mem_err_i = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({walk_ready_o, mem_req_o, fill_req_o, done_o, page_fault_o, access_fault_o} !== 6'b100000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 100000",
                {walk_ready_o, mem_req_o, fill_req_o, done_o, page_fault_o, access_fault_o});
        end
        checks++;
        if ({mem_addr_o, fill_vpn_o, fill_ppn_o, fill_perm_o, fill_superpage_o} !== '0) begin
            errors++; $display("FAIL reset_data: got addr %h vpn %h ppn %h perm %h sp %b expected all 0",
                mem_addr_o, fill_vpn_o, fill_ppn_o, fill_perm_o, fill_superpage_o);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if (walk_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++; $display("FAIL reset_release: ready %b req %b expected 1 0", walk_ready_o, mem_req_o);
        end
    endtask

    task automatic test_directed();
        vec_t vt [11];
        res_t o, e;
        vt[0]  = mkvec(32'h80, 32'h4000_1234, 32'h2000_0001, 32'h1234_50CF, 0, 0, 0, 0);
        vt[1]  = mkvec(32'h80, 32'h8040_0000, 32'h2000_00CF, 32'h0, 0, 0, 0, 0);
        vt[2]  = mkvec(32'h80, 32'h8040_0000, 32'h2000_04CF, 32'h0, 0, 0, 0, 0);
        vt[3]  = mkvec(32'h80, 32'h1234_5678, 32'h2000_00CE, 32'h0, 0, 0, 1, 0);
        vt[4]  = mkvec(32'h80, 32'h1234_5678, 32'h2000_0005, 32'h0, 0, 0, 0, 0);
        vt[5]  = mkvec(32'h80, 32'h1234_5678, 32'h2000_008F, 32'h0, 0, 0, 0, 0);
        vt[6]  = mkvec(32'h80, 32'h4000_1234, 32'h2000_0001, 32'h2000_0001, 0, 0, 0, 2);
        vt[7]  = mkvec(32'h80, 32'h4000_1234, 32'h2000_0001, 32'h1234_50CF, 0, 1, 0, 1);
        vt[8]  = mkvec(32'h80, 32'h4000_1234, 32'h2000_0001, 32'h1234_50CF, 0, 0, NO_ACK, 0);
        vt[9]  = mkvec(32'h80, 32'h4000_1234, 32'h2000_0001, 32'h1234_50CF, 0, 0, 2, 3);
        vt[10] = mkvec(32'h80, 32'h4000_1234, 32'h2000_0001, 32'h1234_50CF, 0, 0, 1, NO_ACK);
        for (int i = 0; i < 11; i++) begin
            e = model(vt[i]);
            do_walk(vt[i], o);
            checks++;
            if (o.hung || o.outcome != e.outcome) begin
                errors++; $display("FAIL dir%0d_outcome: got %0d hung %b expected %0d", i, o.outcome, o.hung, e.outcome);
            end
            checks++;
            if (o.done_cyc != e.done_cyc || o.req_at_done !== 1'b0) begin
                errors++; $display("FAIL dir%0d_timing: got cycle %0d req %b expected %0d 0", i, o.done_cyc, o.req_at_done, e.done_cyc);
            end
            checks++;
            if (o.nreq != e.nreq || o.addr1 !== e.addr1 || (e.nreq == 2 && o.addr0 !== e.addr0) || !o.stable || !o.rdy) begin
                errors++; $display("FAIL dir%0d_mem: got n %0d a1 %h a0 %h st %b rdy %b expected n %0d a1 %h a0 %h", i,
                    o.nreq, o.addr1, o.addr0, o.stable, o.rdy, e.nreq, e.addr1, e.addr0);
            end
            if (e.outcome == 0) begin
                checks++;
                if (o.vpn !== e.vpn || o.ppn !== e.ppn || o.perm !== e.perm || o.sp !== e.sp) begin
                    errors++; $display("FAIL dir%0d_fill: got %h %h %h %b expected %h %h %h %b", i,
                        o.vpn, o.ppn, o.perm, o.sp, e.vpn, e.ppn, e.perm, e.sp);
                end
            end
            if (i == 0) begin
                checks++;
                if (o.addr1 !== 32'h0008_0400 || o.addr0 !== 32'h8000_0004 || o.perm !== 7'h67 || o.vpn !== 20'h40001) begin
                    errors++; $display("FAIL dir0_literal: got a1 %h a0 %h perm %h vpn %h expected 00080400 80000004 67 40001",
                        o.addr1, o.addr0, o.perm, o.vpn);
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_pte(bit l1);
        logic [31:0] p;
        p = $urandom;
        case ($urandom_range(0, 3))
            0: p[3:0] = 4'b0001;
            1, 2: begin
                p[0] = 1'b1; p[1] = 1'b1; p[6] = 1'b1;
                if (l1 && $urandom_range(0, 1) == 1) p[19:10] = '0;
            end
            default: ;
        endcase
        return p;
    endfunction

    task automatic test_random();
        vec_t v;
        res_t o, e;
        for (int i = 0; i < 60; i++) begin
            v = mkvec($urandom, $urandom, rand_pte(1), rand_pte(0),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 3), $urandom_range(0, 3));
            e = model(v);
            do_walk(v, o);
            checks++;
            if (o.hung || o.outcome != e.outcome || o.done_cyc != e.done_cyc || o.req_at_done !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_result: got out %0d cyc %0d hung %b expected out %0d cyc %0d",
                    i, o.outcome, o.done_cyc, o.hung, e.outcome, e.done_cyc);
            end
            checks++;
            if (o.nreq != e.nreq || o.addr1 !== e.addr1 || (e.nreq == 2 && o.addr0 !== e.addr0) || !o.stable || !o.rdy) begin
                errors++; $display("FAIL rnd%0d_mem: got n %0d a1 %h a0 %h st %b expected n %0d a1 %h a0 %h",
                    i, o.nreq, o.addr1, o.addr0, o.stable, e.nreq, e.addr1, e.addr0);
            end
            if (e.outcome == 0) begin
                checks++;
                if (o.vpn !== e.vpn || o.ppn !== e.ppn || o.perm !== e.perm || o.sp !== e.sp) begin
                    errors++; $display("FAIL rnd%0d_fill: got %h %h %h %b expected %h %h %h %b",
                        i, o.vpn, o.ppn, o.perm, o.sp, e.vpn, e.ppn, e.perm, e.sp);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] a;
        int          bad;
        // flush while the level-1 read is outstanding; ack arrives three cycles later
        @(negedge clk);
        walk_req_i = 1; walk_vaddr_i = 32'h4000_1234; satp_i = 32'h80;
        @(negedge clk);
        walk_req_i = 0; flush_i = 1; a = mem_addr_o; bad = 0;
        if (mem_req_o !== 1'b1) bad++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            flush_i = 0;
            if (mem_req_o !== 1'b1 || mem_addr_o !== a || done_o !== 1'b0) bad++;
            if (k == 2) begin mem_ack_i = 1; mem_rdata_i = 32'h2000_00CF; end
        end
        @(negedge clk);
        mem_ack_i = 0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL flush_drain_hold: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (mem_req_o !== 1'b0 || walk_ready_o !== 1'b1 || done_o !== 1'b0 || fill_req_o !== 1'b0) begin
            errors++; $display("FAIL flush_drain_end: got req %b rdy %b done %b fill %b expected 0 1 0 0",
                mem_req_o, walk_ready_o, done_o, fill_req_o);
        end
        // flush with ack in the same cycle returns straight to idle
        walk_req_i = 1;
        @(negedge clk);
        walk_req_i = 0; flush_i = 1; mem_ack_i = 1; mem_rdata_i = 32'h2000_00CF;
        @(negedge clk);
        flush_i = 0; mem_ack_i = 0;
        checks++;
        if (mem_req_o !== 1'b0 || walk_ready_o !== 1'b1 || done_o !== 1'b0) begin
            errors++; $display("FAIL flush_same_ack: got req %b rdy %b done %b expected 0 1 0", mem_req_o, walk_ready_o, done_o);
        end
        // flush in the completion cycle suppresses the fill
        walk_req_i = 1; walk_vaddr_i = 32'h8040_0000;
        @(negedge clk);
        walk_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h2000_00CF;
        @(negedge clk);
        mem_ack_i = 0;
        checks++;
        if (done_o !== 1'b1 || fill_req_o !== 1'b1) begin
            errors++; $display("FAIL flush_done_pre: got done %b fill %b expected 1 1", done_o, fill_req_o);
        end
        flush_i = 1;
        #1;
        checks++;
        if (done_o !== 1'b0 || fill_req_o !== 1'b0 || page_fault_o !== 1'b0 || access_fault_o !== 1'b0) begin
            errors++; $display("FAIL flush_done_gate: got done %b fill %b expected 0 0", done_o, fill_req_o);
        end
        @(negedge clk);
        // flush beats a walk request in idle
        walk_req_i = 1;
        @(negedge clk);
        walk_req_i = 0; flush_i = 0;
        checks++;
        if (walk_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++; $display("FAIL flush_idle_prio: got rdy %b req %b expected 1 0", walk_ready_o, mem_req_o);
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [2];
        res_t o, e;
        v[0] = mkvec(32'h0012_3456, 32'hDEAD_B000, 32'h0000_0401, 32'h0ABC_D0CB, 0, 0, 0, 0);
        v[1] = mkvec(32'h0000_0777, 32'h0040_0000, 32'h1230_00DB, 32'h0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            e = model(v[i]);
            do_walk(v[i], o);
            checks++;
            if (o.hung || o.outcome != e.outcome || o.done_cyc != e.done_cyc || !o.rdy ||
                o.ppn !== e.ppn || o.sp !== e.sp || o.addr1 !== e.addr1) begin
                errors++; $display("FAIL b2b%0d: got out %0d cyc %0d ppn %h sp %b rdy %b expected out %0d cyc %0d ppn %h sp %b",
                    i, o.outcome, o.done_cyc, o.ppn, o.sp, o.rdy, e.outcome, e.done_cyc, e.ppn, e.sp);
            end
        end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        walk_req_i = 1; walk_vaddr_i = 32'h4000_1234; satp_i = 32'h80;
        @(negedge clk);
        walk_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h2000_0001;
        @(negedge clk);
        mem_ack_i = 0;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0004) begin
            errors++; $display("FAIL rst_mid_l0: got req %b addr %h expected 1 80000004", mem_req_o, mem_addr_o);
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if ({walk_ready_o, mem_req_o, fill_req_o, done_o, page_fault_o, access_fault_o} !== 6'b100000 ||
            mem_addr_o !== '0 || fill_ppn_o !== '0 || fill_vpn_o !== '0) begin
            errors++; $display("FAIL rst_mid_out: got rdy %b req %b addr %h ppn %h expected 1 0 0 0",
                walk_ready_o, mem_req_o, mem_addr_o, fill_ppn_o);
        end
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; satp_i = '0; walk_req_i = 0; walk_vaddr_i = '0; flush_i = 0;
        mem_ack_i = 0; mem_rdata_i = '0; mem_err_i = 0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
